// File: rtl/alu_issue_stage.sv
// ---------------------------------------------------------------------------
// alu_issue_stage
//
// ID/EX pipeline register on the driving side of the combinational ALU.
// A decoded-register RV32I instruction (word, PC, register read data) is
// accepted through a valid/ready handshake. It is decoded into ALU controls,
// and the operands and controls are registered. They then stay bit-stable
// until the EX stage consumes them.
//
// Handshake semantics (both sides):
//   A transfer happens on a rising edge where valid and ready are both 1.
//   A producer that raises valid keeps its payload until the transfer.
//   Upstream: in_ready = !ex_valid || ex_ready (combinational, no skid buffer),
//     and an accept is in_valid && in_ready && !flush.
//   Downstream: ex_valid and all payload outputs are registered. They are held
//     bit-stable while ex_valid && !ex_ready.
//   flush drops both the held and the incoming instruction. rst_n overrides
//   flush.
//
// Parameters:
//   WIDTH          datapath width of operands and PC (>= 32)
//
// Ports:
//   clk, rst_n     rising-edge clock, synchronous active-low reset
//   in_valid       ID presents a valid instruction
//   in_ready       stage can accept this cycle
//   instr          RV32I instruction word
//   pc             instruction PC
//   rs1_data       register-file read data for rs1
//   rs2_data       register-file read data for rs2
//   flush          kill held and incoming instruction
//   ex_valid       registered ALU outputs are valid
//   ex_ready       EX consumes this cycle
//   in1            ALU operand A
//   rs2_out        ALU operand B (rs2 or immediate)
//   ALUOp_control  ALU operation code
//   funct3         instr[14:12] passed through (branch compare)
//   opcode         instr[6:0] passed through
//   rd             destination register instr[11:7]
//   illegal        held instruction failed decode (meaningful with ex_valid)
// ---------------------------------------------------------------------------
module alu_issue_stage #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    input  logic [WIDTH-1:0] pc,
    input  logic [WIDTH-1:0] rs1_data,
    input  logic [WIDTH-1:0] rs2_data,
    input  logic             flush,
    output logic             ex_valid,
    input  logic             ex_ready,
    output logic [WIDTH-1:0] in1,
    output logic [WIDTH-1:0] rs2_out,
    output logic [3:0]       ALUOp_control,
    output logic [2:0]       funct3,
    output logic [6:0]       opcode,
    output logic [4:0]       rd,
    output logic             illegal
);

    // ALU operation codes
    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0011;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_SLTU = 4'b1000;
    localparam logic [3:0] ALU_SLL  = 4'b1001;
    localparam logic [3:0] ALU_SRL  = 4'b1010;
    localparam logic [3:0] ALU_SRA  = 4'b1011;

    // Major opcodes
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // Instruction fields
    logic [6:0] f_opcode;
    logic [2:0] f_funct3;
    logic [6:0] f_funct7;

    assign f_opcode = instr[6:0];
    assign f_funct3 = instr[14:12];
    assign f_funct7 = instr[31:25];

    // Immediates, sign-extended to the datapath width through a signed cast
    logic [WIDTH-1:0] imm_i;
    logic [WIDTH-1:0] imm_s;
    logic [WIDTH-1:0] imm_u;
    logic [WIDTH-1:0] imm_shamt;

    assign imm_i     = WIDTH'($signed(instr[31:20]));
    assign imm_s     = WIDTH'($signed({instr[31:25], instr[11:7]}));
    assign imm_u     = WIDTH'($signed({instr[31:12], 12'b0}));
    assign imm_shamt = WIDTH'(instr[24:20]);

    // Shared funct3 -> ALU op mapping for the base (funct7 = 0) encodings
    function automatic logic [3:0] base_op(input logic [2:0] f3);
        logic [3:0] op;
        case (f3)
            3'b000:  op = ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    // Combinational decode of the incoming instruction
    logic [WIDTH-1:0] dec_in1;
    logic [WIDTH-1:0] dec_rs2;
    logic [3:0]       dec_op;
    logic [4:0]       dec_rd;
    logic             dec_illegal;

    always_comb begin
        dec_in1     = rs1_data;
        dec_rs2     = rs2_data;
        dec_op      = ALU_ADD;
        dec_illegal = 1'b0;

        case (f_opcode)
            OPC_OP: begin
                if (f_funct7 == F7_BASE) begin
                    dec_op = base_op(f_funct3);
                end else if (f_funct7 == F7_ALT && f_funct3 == 3'b000) begin
                    dec_op = ALU_SUB;
                end else if (f_funct7 == F7_ALT && f_funct3 == 3'b101) begin
                    dec_op = ALU_SRA;
                end else begin
                    dec_illegal = 1'b1;
                end
            end
            OPC_OP_IMM: begin
                dec_rs2 = imm_i;
                dec_op  = base_op(f_funct3);
                // Shift-immediates take a 5-bit shamt and use instr[31:25]
                // as a funct7 selector rather than as immediate bits.
                if (f_funct3 == 3'b001) begin
                    dec_rs2 = imm_shamt;
                    if (f_funct7 != F7_BASE) begin
                        dec_illegal = 1'b1;
                    end
                end else if (f_funct3 == 3'b101) begin
                    dec_rs2 = imm_shamt;
                    if (f_funct7 == F7_ALT) begin
                        dec_op = ALU_SRA;
                    end else if (f_funct7 != F7_BASE) begin
                        dec_illegal = 1'b1;
                    end
                end
            end
            OPC_BRANCH: begin
                // Compare is done by subtraction; funct3 picks the condition
                dec_op = ALU_SUB;
                if (f_funct3 == 3'b010 || f_funct3 == 3'b011) begin
                    dec_illegal = 1'b1;
                end
            end
            OPC_LOAD: begin
                dec_rs2 = imm_i;
            end
            OPC_STORE: begin
                dec_rs2 = imm_s;
            end
            OPC_LUI: begin
                dec_in1 = '0;
                dec_rs2 = imm_u;
            end
            OPC_AUIPC: begin
                dec_in1 = pc;
                dec_rs2 = imm_u;
            end
            default: begin
                dec_illegal = 1'b1;
            end
        endcase

        // Illegal instructions present neutral operands; downstream traps
        if (dec_illegal) begin
            dec_op  = ALU_ADD;
            dec_in1 = '0;
            dec_rs2 = '0;
        end
    end

    assign dec_rd = dec_illegal ? 5'd0 : instr[11:7];

    // Handshake
    logic accept;

    assign in_ready = !ex_valid || ex_ready;
    assign accept   = in_valid && in_ready && !flush;

    // Output register. Data registers change only on accept, so they hold
    // across consume, flush and back-pressure.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_valid      <= 1'b0;
            in1           <= '0;
            rs2_out       <= '0;
            ALUOp_control <= 4'b0000;
            funct3        <= 3'b000;
            opcode        <= 7'b0000000;
            rd            <= 5'd0;
            illegal       <= 1'b0;
        end else if (flush) begin
            ex_valid <= 1'b0;
        end else if (accept) begin
            ex_valid      <= 1'b1;
            in1           <= dec_in1;
            rs2_out       <= dec_rs2;
            ALUOp_control <= dec_op;
            funct3        <= f_funct3;
            opcode        <= f_opcode;
            rd            <= dec_rd;
            illegal       <= dec_illegal;
        end else if (ex_ready) begin
            ex_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_issue_stage.sv
// ---------------------------------------------------------------------------
// tb_alu_issue_stage
//
// Testbench for alu_issue_stage (WIDTH = 32). A transaction-level reference
// model tracks the expected contents of the stage register. Instructions are
// decoded to a mnemonic, and the mnemonic is mapped to an ALU code. Directed
// steps follow the test plan, then a randomized run follows. Inputs change
// just after the falling edge, and outputs are sampled at the falling edge.
// ---------------------------------------------------------------------------
module tb_alu_issue_stage;

    localparam int W = 32;

    typedef struct packed {
        logic [W-1:0] in1;
        logic [W-1:0] b;
        logic [3:0]   op;
        logic [2:0]   f3;
        logic [6:0]   opc;
        logic [4:0]   rd;
        logic         ill;
    } exp_t;

    localparam int EW = $bits(exp_t);

    // ------------------------------------------------------------ clock/reset
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    // ------------------------------------------------------------ DUT
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [31:0]  instr = '0;
    logic [W-1:0] pc = '0;
    logic [W-1:0] rs1_data = '0;
    logic [W-1:0] rs2_data = '0;
    logic         flush = 1'b0;
    logic         ex_valid;
    logic         ex_ready = 1'b0;
    logic [W-1:0] in1;
    logic [W-1:0] rs2_out;
    logic [3:0]   ALUOp_control;
    logic [2:0]   funct3;
    logic [6:0]   opcode;
    logic [4:0]   rd;
    logic         illegal;

    alu_issue_stage #(.WIDTH(W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .instr         (instr),
        .pc            (pc),
        .rs1_data      (rs1_data),
        .rs2_data      (rs2_data),
        .flush         (flush),
        .ex_valid      (ex_valid),
        .ex_ready      (ex_ready),
        .in1           (in1),
        .rs2_out       (rs2_out),
        .ALUOp_control (ALUOp_control),
        .funct3        (funct3),
        .opcode        (opcode),
        .rd            (rd),
        .illegal       (illegal)
    );

    // ------------------------------------------------------------ bookkeeping
    int total = 0;
    int bad   = 0;

    exp_t         m;          // expected stage register contents
    logic         m_valid;    // expected ex_valid
    logic [EW-1:0] exp_q[$];  // accepted, not yet consumed transactions

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t observed();
        exp_t o;
        o.in1 = in1;
        o.b   = rs2_out;
        o.op  = ALUOp_control;
        o.f3  = funct3;
        o.opc = opcode;
        o.rd  = rd;
        o.ill = illegal;
        return o;
    endfunction

    // ------------------------------------------------------------ reference model
    string names8 [8] = '{"ADD", "SLL", "SLT", "SLTU", "XOR", "SRL", "OR", "AND"};

    function automatic logic [3:0] code_of(input string mn);
        case (mn)
            "AND":   return 4'b0000;
            "OR":    return 4'b0001;
            "ADD":   return 4'b0010;
            "XOR":   return 4'b0011;
            "SUB":   return 4'b0110;
            "SLT":   return 4'b0111;
            "SLTU":  return 4'b1000;
            "SLL":   return 4'b1001;
            "SRL":   return 4'b1010;
            "SRA":   return 4'b1011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic exp_t ref_dec(input logic [31:0] ins, input logic [W-1:0] p,
                                     input logic [W-1:0] a, input logic [W-1:0] bv);
        exp_t e;
        string mn;
        logic [6:0] opc;
        logic [2:0] f3;
        logic [6:0] f7;
        logic [31:0] imm_i;
        logic [31:0] imm_s;
        logic [31:0] imm_u;
        opc   = ins[6:0];
        f3    = ins[14:12];
        f7    = ins[31:25];
        imm_i = {{20{ins[31]}}, ins[31:20]};
        imm_s = {{20{ins[31]}}, ins[31:25], ins[11:7]};
        imm_u = {ins[31:12], 12'h000};
        e.in1 = a;
        e.b   = bv;
        e.f3  = f3;
        e.opc = opc;
        e.rd  = ins[11:7];
        mn    = "";
        case (opc)
            7'h33: begin
                if (f7 == 7'h00)                  mn = names8[f3];
                else if (f7 == 7'h20 && f3 == 0)  mn = "SUB";
                else if (f7 == 7'h20 && f3 == 5)  mn = "SRA";
            end
            7'h13: begin
                mn  = names8[f3];
                e.b = imm_i;
                if (f3 == 1 || f3 == 5) begin
                    e.b = {27'h0, ins[24:20]};
                    if (f3 == 5 && f7 == 7'h20) mn = "SRA";
                    else if (f7 != 7'h00)       mn = "";
                end
            end
            7'h63: mn = (f3 == 2 || f3 == 3) ? "" : "SUB";
            7'h03: begin mn = "ADD"; e.b = imm_i; end
            7'h23: begin mn = "ADD"; e.b = imm_s; end
            7'h37: begin mn = "ADD"; e.in1 = '0; e.b = imm_u; end
            7'h17: begin mn = "ADD"; e.in1 = p;  e.b = imm_u; end
            default: mn = "";
        endcase
        if (mn == "") begin
            e.ill = 1'b1;
            e.op  = 4'b0010;
            e.in1 = '0;
            e.b   = '0;
            e.rd  = 5'd0;
        end else begin
            e.ill = 1'b0;
            e.op  = code_of(mn);
        end
        return e;
    endfunction

    // ------------------------------------------------------------ driver tasks
    task automatic set_in(input logic v, input logic [31:0] ins, input logic [W-1:0] p,
                          input logic [W-1:0] a, input logic [W-1:0] bv);
        in_valid = v;
        instr    = ins;
        pc       = p;
        rs1_data = a;
        rs2_data = bv;
    endtask

    // One clock: check the handshake, advance the model, then check outputs
    task automatic cyc();
        exp_t nx;
        logic nv;
        logic acc;
        #1;
        check("in_ready", 128'(in_ready), 128'(!m_valid || ex_ready));
        acc = in_valid && (!m_valid || ex_ready) && !flush;
        nx  = m;
        nv  = m_valid;
        if (!rst_n) begin
            nx = '0;
            nv = 1'b0;
            exp_q.delete();
        end else if (flush) begin
            nv = 1'b0;
            exp_q.delete();
        end else begin
            if (m_valid && ex_ready) begin
                if (exp_q.size() == 0) begin
                    check("consume_queue_empty", 128'(1), 128'(0));
                end else begin
                    check("consumed", 128'(observed()), 128'(exp_q.pop_front()));
                end
                nv = 1'b0;
            end
            if (acc) begin
                nx = ref_dec(instr, pc, rs1_data, rs2_data);
                nv = 1'b1;
                exp_q.push_back(nx);
            end
        end
        @(posedge clk);
        @(negedge clk);
        m       = nx;
        m_valid = nv;
        check("ex_valid", 128'(ex_valid), 128'(m_valid));
        check("outputs", 128'(observed()), 128'(m));
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        logic [6:0]  f7;
        int k;
        r = $urandom;
        k = $urandom_range(0, 2);
        f7 = (k == 0) ? 7'h00 : (k == 1) ? 7'h20 : r[31:25];
        case ($urandom_range(0, 9))
            0, 1: r = {f7, r[24:7], 7'h33};
            2, 3: r = {f7, r[24:7], 7'h13};
            4:    r = {r[31:7], 7'h63};
            5:    r = {r[31:7], 7'h03};
            6:    r = {r[31:7], 7'h23};
            7:    r = {r[31:7], 7'h37};
            8:    r = {r[31:7], 7'h17};
            default: ;
        endcase
        return r;
    endfunction

    // ------------------------------------------------------------ stimulus
    initial begin
        // Power-on reset
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        m       = '0;
        m_valid = 1'b0;
        check("reset_ex_valid", 128'(ex_valid), 128'(0));
        check("reset_outputs", 128'(observed()), 128'(0));
        check("reset_in_ready", 128'(in_ready), 128'(1));
        rst_n = 1'b1;

        // Reset mid-transfer
        ex_ready = 1'b0;
        set_in(1'b1, 32'hFFB0_0093, 32'h0, 32'h0, 32'h0);
        cyc();
        check("midrst_valid_before", 128'(ex_valid), 128'(1));
        set_in(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        check("midrst_outputs", 128'(observed()), 128'(0));
        check("midrst_in_ready", 128'(in_ready), 128'(1));

        // R-type SUB x3,x1,x2
        ex_ready = 1'b1;
        set_in(1'b1, 32'h4020_81B3, 32'h0, 32'd20, 32'd7);
        cyc();
        check("sub_in1", 128'(in1), 128'(20));
        check("sub_rs2", 128'(rs2_out), 128'(7));
        check("sub_op", 128'(ALUOp_control), 128'(4'b0110));
        check("sub_rd", 128'(rd), 128'(3));
        check("sub_ill", 128'(illegal), 128'(0));

        // SRAI x5,x6,2 and ADDI x1,x0,-5
        set_in(1'b1, 32'h4023_5293, 32'h0, 32'h8000_0000, 32'h0);
        cyc();
        check("srai_op", 128'(ALUOp_control), 128'(4'b1011));
        check("srai_rs2", 128'(rs2_out), 128'(2));
        set_in(1'b1, 32'hFFB0_0093, 32'h0, 32'h0, 32'h0);
        cyc();
        check("addi_rs2", 128'(rs2_out), 128'(32'hFFFF_FFFB));
        check("addi_op", 128'(ALUOp_control), 128'(4'b0010));

        // Back-pressure: BEQ held for three cycles while inputs change
        set_in(1'b1, 32'h0020_8463, 32'h40, 32'd9, 32'd9);
        cyc();
        ex_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_in(1'($urandom_range(0, 1)), rand_instr(), $urandom, $urandom, $urandom);
            cyc();
            check("bp_in_ready", 128'(in_ready), 128'(0));
            check("bp_op_held", 128'(ALUOp_control), 128'(4'b0110));
        end
        // Release with a new instruction: loads with no bubble
        ex_ready = 1'b1;
        set_in(1'b1, 32'h0020_C1B3, 32'h0, 32'h0F0F_0F0F, 32'h00FF_00FF);
        cyc();
        check("bp_next_valid", 128'(ex_valid), 128'(1));
        check("bp_next_op", 128'(ALUOp_control), 128'(4'b0011));

        // Flush coincident with an acceptable instruction
        flush = 1'b1;
        set_in(1'b1, 32'h0020_81B3, 32'h0, 32'd1, 32'd2);
        cyc();
        check("flush_valid", 128'(ex_valid), 128'(0));
        flush = 1'b0;
        set_in(1'b1, 32'h0000_1117, 32'h100, 32'h0, 32'h0);
        cyc();
        check("auipc_in1", 128'(in1), 128'(32'h100));
        check("auipc_rs2", 128'(rs2_out), 128'(32'h1000));
        check("auipc_op", 128'(ALUOp_control), 128'(4'b0010));

        // Illegal encodings, then BLTU
        set_in(1'b1, 32'hFFFF_FFFF, 32'h200, 32'd5, 32'd6);
        cyc();
        check("ill_opc_flag", 128'(illegal), 128'(1));
        check("ill_opc_in1", 128'(in1), 128'(0));
        set_in(1'b1, 32'h0220_81B3, 32'h0, 32'd5, 32'd6);
        cyc();
        check("ill_f7_flag", 128'(illegal), 128'(1));
        check("ill_f7_op", 128'(ALUOp_control), 128'(4'b0010));
        check("ill_f7_rs2", 128'(rs2_out), 128'(0));
        check("ill_f7_rd", 128'(rd), 128'(0));
        set_in(1'b1, 32'h0020_E463, 32'h0, 32'd5, 32'd6);
        cyc();
        check("bltu_ill", 128'(illegal), 128'(0));
        check("bltu_op", 128'(ALUOp_control), 128'(4'b0110));
        check("bltu_f3", 128'(funct3), 128'(3'b110));

        // Randomized traffic against the model
        for (int i = 0; i < 500; i++) begin
            set_in(1'($urandom_range(0, 9) < 7), rand_instr(), $urandom, $urandom, $urandom);
            ex_ready = 1'($urandom_range(0, 9) < 6);
            flush    = 1'($urandom_range(0, 19) == 0);
            rst_n    = !($urandom_range(0, 99) == 0);
            cyc();
        end
        rst_n = 1'b1;
        flush = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
